// File: rtl/scene_sequencer.sv
// Scene scheduler: counts frame pulses, picks the next pattern by playback mode
// and runs a 16-step ordered-dither dissolve (or a hard cut) between scenes.
module scene_sequencer #(
    parameter int NUM_PATTERNS       = 4,
    parameter int SEL_W              = 2,
    parameter int FRAMES_PER_PATTERN = 240,
    parameter int FADE_EN            = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             next_frame,
    input  logic [1:0]       mode,
    input  logic             skip,
    input  logic [1:0]       x_lsb,
    input  logic [1:0]       y_lsb,
    output logic [SEL_W-1:0] cur_select,
    output logic [SEL_W-1:0] nxt_select,
    output logic             fading,
    output logic [3:0]       fade_level,
    output logic             pix_use_next,
    output logic             scene_done
);

    localparam logic [0:0]       S_PLAY     = 1'b0;
    localparam logic [0:0]       S_FADE     = 1'b1;
    localparam logic [1:0]       M_PINGPONG = 2'd1;
    localparam logic [1:0]       M_RANDOM   = 2'd2;
    localparam logic [1:0]       M_HOLD     = 2'd3;
    localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_PATTERNS - 1);
    localparam logic [SEL_W-1:0] SEL_ONE    = SEL_W'(1);
    localparam logic [7:0]       FRAME_LAST = 8'(FRAMES_PER_PATTERN - 1);
    localparam logic [15:0]      LFSR_SEED  = 16'hACE1;

    logic [0:0]       state;
    logic [7:0]       frame_cnt;
    logic             dir_up;
    logic [15:0]      lfsr;
    logic             lfsr_fb;
    logic [SEL_W-1:0] seq_succ;
    logic [SEL_W-1:0] succ;
    logic [SEL_W-1:0] cand;
    logic             dir_nxt;
    logic             counting;
    logic             start;

    function automatic logic [3:0] bayer(input logic [1:0] y, input logic [1:0] x);
        logic [3:0] b;
        case ({y, x})
            4'h0: b = 4'd0;   4'h1: b = 4'd8;   4'h2: b = 4'd2;   4'h3: b = 4'd10;
            4'h4: b = 4'd12;  4'h5: b = 4'd4;   4'h6: b = 4'd14;  4'h7: b = 4'd6;
            4'h8: b = 4'd3;   4'h9: b = 4'd11;  4'hA: b = 4'd1;   4'hB: b = 4'd9;
            4'hC: b = 4'd15;  4'hD: b = 4'd7;   4'hE: b = 4'd13;  default: b = 4'd5;
        endcase
        return b;
    endfunction

    assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign counting = next_frame && (mode != M_HOLD);
    // skip has priority; a coincident next_frame is swallowed by the transition
    assign start    = skip || (counting && (frame_cnt == FRAME_LAST));
    assign cand     = lfsr[SEL_W-1:0];

    always_comb begin
        seq_succ = (cur_select == SEL_LAST) ? '0 : cur_select + SEL_ONE;
        succ     = seq_succ;
        dir_nxt  = dir_up;
        case (mode)
            M_PINGPONG: begin
                if (dir_up) begin
                    if (cur_select == SEL_LAST) begin
                        succ    = cur_select - SEL_ONE;
                        dir_nxt = 1'b0;
                    end else begin
                        succ = cur_select + SEL_ONE;
                    end
                end else begin
                    if (cur_select == '0) begin
                        succ    = SEL_ONE;
                        dir_nxt = 1'b1;
                    end else begin
                        succ = cur_select - SEL_ONE;
                    end
                end
            end
            M_RANDOM: begin
                // out-of-range or repeat candidates fall back to sequential
                if ((cand > SEL_LAST) || (cand == cur_select)) succ = seq_succ;
                else                                          succ = cand;
            end
            default: succ = seq_succ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_PLAY;
            frame_cnt    <= 8'd0;
            dir_up       <= 1'b1;
            lfsr         <= LFSR_SEED;
            cur_select   <= '0;
            nxt_select   <= '0;
            fading       <= 1'b0;
            fade_level   <= 4'd0;
            pix_use_next <= 1'b0;
            scene_done   <= 1'b0;
        end else begin
            lfsr         <= {lfsr[14:0], lfsr_fb};
            scene_done   <= 1'b0;
            pix_use_next <= fading && (bayer(y_lsb, x_lsb) <= fade_level);
            case (state)
                S_PLAY: begin
                    if (start) begin
                        nxt_select <= succ;
                        frame_cnt  <= 8'd0;
                        dir_up     <= dir_nxt;
                        if (FADE_EN != 0) begin
                            fading     <= 1'b1;
                            fade_level <= 4'd0;
                            state      <= S_FADE;
                        end else begin
                            cur_select <= succ;
                            scene_done <= 1'b1;
                        end
                    end else if (counting) begin
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                end
                S_FADE: begin
                    if (next_frame) begin
                        if (fade_level == 4'd15) begin
                            cur_select <= nxt_select;
                            fading     <= 1'b0;
                            fade_level <= 4'd0;
                            scene_done <= 1'b1;
                            state      <= S_PLAY;
                        end else begin
                            fade_level <= fade_level + 4'd1;
                        end
                    end
                end
                default: state <= S_PLAY;
            endcase
        end
    end

endmodule

// File: tb/tb_scene_sequencer.sv
// Directed bench for scene_sequencer: three instances (4-pattern fade, 4-pattern
// hard cut, 3-pattern fade) share one stimulus stream; each phase checks one of them.
module tb_scene_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, next_frame, skip;
    logic [1:0] mode, x_lsb, y_lsb;

    logic [1:0] a_cur, a_nxt, c_cur_o, c_nxt, b_cur, b_nxt;
    logic [3:0] a_lvl, c_lvl, b_lvl;
    logic       a_fad, a_pix, a_done, c_fad, c_pix, c_done, b_fad, b_pix, b_done;

    int vectors = 0, miscompares = 0;
    int exp_q[$];
    int bayer_t[4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};
    int pp_seq[5] = '{1, 2, 1, 0, 1};
    int c_model, c_fc, m, seen, hits, prev;
    bit chk_c;

    always #5 clk = ~clk;

    scene_sequencer #(.NUM_PATTERNS(4), .SEL_W(2), .FRAMES_PER_PATTERN(4), .FADE_EN(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .next_frame(next_frame), .mode(mode), .skip(skip),
        .x_lsb(x_lsb), .y_lsb(y_lsb), .cur_select(a_cur), .nxt_select(a_nxt), .fading(a_fad),
        .fade_level(a_lvl), .pix_use_next(a_pix), .scene_done(a_done));

    scene_sequencer #(.NUM_PATTERNS(4), .SEL_W(2), .FRAMES_PER_PATTERN(4), .FADE_EN(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .next_frame(next_frame), .mode(mode), .skip(skip),
        .x_lsb(x_lsb), .y_lsb(y_lsb), .cur_select(c_cur_o), .nxt_select(c_nxt), .fading(c_fad),
        .fade_level(c_lvl), .pix_use_next(c_pix), .scene_done(c_done));

    scene_sequencer #(.NUM_PATTERNS(3), .SEL_W(2), .FRAMES_PER_PATTERN(4), .FADE_EN(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .next_frame(next_frame), .mode(mode), .skip(skip),
        .x_lsb(x_lsb), .y_lsb(y_lsb), .cur_select(b_cur), .nxt_select(b_nxt), .fading(b_fad),
        .fade_level(b_lvl), .pix_use_next(b_pix), .scene_done(b_done));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // next_frame held high for n consecutive cycles; optionally tracks the hard-cut instance
    task automatic pulses(input int n);
        next_frame = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            if (chk_c) begin
                if (c_fc == 3) begin
                    c_fc    = 0;
                    c_model = (c_model + 1) % 4;
                    check("cut_done", c_done, 1);
                end else begin
                    c_fc++;
                    check("cut_quiet", c_done, 0);
                end
                check("cut_cur", c_cur_o, c_model);
            end
        end
        next_frame = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; next_frame = 1'b0; skip = 1'b0;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic sweep(input int lvl, input bit fad, input int want_hits);
        int got;
        hits = 0;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                x_lsb = 2'(x); y_lsb = 2'(y);
                exp_q.push_back((fad && bayer_t[y][x] <= lvl) ? 1 : 0);
                step();
                got = exp_q.pop_front();
                check("dither_pix", a_pix, got);
                if (a_pix === 1'b1) hits++;
            end
        end
        check("dither_hits", hits, want_hits);
    endtask

    initial begin
        rst_n = 1'b0; next_frame = 1'b0; skip = 1'b0; mode = 2'd0;
        x_lsb = 2'd0; y_lsb = 2'd0; chk_c = 1'b0;
        step(); step();
        check("rst_cur", a_cur, 0);
        check("rst_nxt", a_nxt, 0);
        check("rst_fading", a_fad, 0);
        check("rst_level", a_lvl, 0);
        check("rst_pix", a_pix, 0);
        check("rst_done", a_done, 0);
        check("rst_cut_cur", c_cur_o, 0);
        check("rst_b_cur", b_cur, 0);
        rst_n = 1'b1;
        sweep(0, 1'b0, 0);

        // sequential, fade and hard cut side by side
        do_reset();
        c_model = 0; c_fc = 0; chk_c = 1'b1; m = 0;
        for (int t = 0; t < 4; t++) begin
            pulses(3);
            check("seq_pre_fade", a_fad, 0);
            pulses(1);
            check("seq_fading", a_fad, 1);
            check("seq_cur_hold", a_cur, m);
            check("seq_nxt", a_nxt, (m + 1) % 4);
            check("seq_lvl0", a_lvl, 0);
            exp_q.push_back((m + 1) % 4);
            pulses(15);
            check("seq_lvl15", a_lvl, 15);
            check("seq_no_done", a_done, 0);
            pulses(1);
            check("seq_done", a_done, 1);
            check("seq_cur", a_cur, exp_q.pop_front());
            check("seq_fade_off", a_fad, 0);
            check("seq_lvl_clr", a_lvl, 0);
            m = (m + 1) % 4;
            step();
            check("seq_done_1cyc", a_done, 0);
        end
        chk_c = 1'b0;

        // dither at level 5, then reset in the middle of the fade
        do_reset();
        pulses(4);
        pulses(5);
        check("mid_lvl5", a_lvl, 5);
        sweep(5, 1'b1, 6);
        rst_n = 1'b0;
        step();
        check("abort_cur", a_cur, 0);
        check("abort_nxt", a_nxt, 0);
        check("abort_fading", a_fad, 0);
        check("abort_lvl", a_lvl, 0);
        check("abort_pix", a_pix, 0);
        check("abort_done", a_done, 0);
        rst_n = 1'b1;
        step();
        check("abort_no_done", a_done, 0);

        // skip beats a coincident next_frame; skip ignored while fading
        do_reset();
        pulses(2);
        next_frame = 1'b1; skip = 1'b1;
        step();
        next_frame = 1'b0; skip = 1'b0;
        check("skip_fading", a_fad, 1);
        check("skip_lvl0", a_lvl, 0);
        check("skip_nxt", a_nxt, 1);
        skip = 1'b1;
        step();
        skip = 1'b0;
        check("skip_in_fade_lvl", a_lvl, 0);
        check("skip_in_fade_on", a_fad, 1);
        mode = 2'd1;
        next_frame = 1'b1; skip = 1'b1;
        step();
        next_frame = 1'b0; skip = 1'b0;
        check("skip_nf_lvl1", a_lvl, 1);
        check("mode_chg_nxt", a_nxt, 1);
        pulses(14);
        check("skip_no_done", a_done, 0);
        pulses(1);
        check("skip_done", a_done, 1);
        check("skip_cur", a_cur, 1);
        mode = 2'd0;
        pulses(3);
        check("frame_cnt_cleared", a_fad, 0);
        pulses(1);
        check("after_skip_fade", a_fad, 1);
        check("after_skip_nxt", a_nxt, 2);

        // hold mode ignores frames, skip still works
        do_reset();
        mode = 2'd3;
        seen = 0;
        next_frame = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (a_fad !== 1'b0 || a_done !== 1'b0 || a_cur !== 2'd0 || a_nxt !== 2'd0) seen++;
        end
        next_frame = 1'b0;
        check("hold_static", seen, 0);
        skip = 1'b1;
        step();
        skip = 1'b0;
        check("hold_skip_fade", a_fad, 1);
        check("hold_skip_nxt", a_nxt, 1);
        check("hold_skip_cur", a_cur, 0);
        pulses(15);
        check("hold_no_done", a_done, 0);
        pulses(1);
        check("hold_done", a_done, 1);
        check("hold_cur", a_cur, 1);

        // ping-pong on three patterns
        do_reset();
        mode = 2'd1;
        for (int i = 0; i < 5; i++) begin
            pulses(4);
            check("pp_fading", b_fad, 1);
            check("pp_nxt", b_nxt, pp_seq[i]);
            exp_q.push_back(pp_seq[i]);
            pulses(16);
            check("pp_done", b_done, 1);
            check("pp_cur", b_cur, exp_q.pop_front());
        end

        // random on three patterns: never a repeat, never out of range
        do_reset();
        mode = 2'd2;
        prev = 0;
        for (int i = 0; i < 64; i++) begin
            skip = 1'b1;
            step();
            skip = 1'b0;
            check("rnd_cur", b_cur, prev);
            check("rnd_not_cur", (b_nxt != b_cur), 1);
            check("rnd_in_range", (b_nxt < 2'd3), 1);
            check("rnd4_not_cur", (a_nxt != a_cur), 1);
            exp_q.push_back(int'(b_nxt));
            pulses(16);
            check("rnd_done", b_done, 1);
            prev = exp_q.pop_front();
            check("rnd_commit", b_cur, prev);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
